// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared, one-cycle-latency ALU.
// Ports: req0/req1 op handshakes, rsp0/rsp1 result buffers, alu_* shared ALU drive/return.
package neocore_pkg;

  typedef enum logic [3:0] {
    ALU_NOP = 4'd0,
    ALU_ADD = 4'd1,
    ALU_SUB = 4'd2,
    ALU_AND = 4'd3,
    ALU_OR  = 4'd4,
    ALU_XOR = 4'd5,
    ALU_MUL = 4'd6,
    ALU_LSH = 4'd7
  } alu_op_e;

endpackage

module alu_arbiter
  import neocore_pkg::*;
#(
  parameter bit PRIO_FIXED = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  alu_op_e     req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  input  alu_op_e     req1_op,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_result,
  output logic        rsp0_z,
  output logic        rsp0_v,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_result,
  output logic        rsp1_z,
  output logic        rsp1_v,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output alu_op_e     alu_op,
  input  logic [31:0] alu_result,
  input  logic        alu_z,
  input  logic        alu_v
);

  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_R0   = 2'd1;
  localparam logic [1:0] TAG_R1   = 2'd2;

  logic       inflight0;
  logic       inflight1;
  logic [1:0] tag1;
  logic [1:0] tag2;
  logic       last1;

  logic elig0;
  logic elig1;
  logic cand0;
  logic cand1;
  logic gnt0;
  logic gnt1;
  logic wr0;
  logic wr1;

  logic [15:0] nxt_a;
  logic [15:0] nxt_b;
  alu_op_e     nxt_op;
  logic [1:0]  nxt_tag;

  // A requester may issue again once its buffer drains this cycle.
  assign elig0 = !inflight0 && (!rsp0_valid || rsp0_ready);
  assign elig1 = !inflight1 && (!rsp1_valid || rsp1_ready);
  assign cand0 = req0_valid && elig0;
  assign cand1 = req1_valid && elig1;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (cand0 && cand1) begin
      if (PRIO_FIXED || last1) gnt0 = 1'b1;
      else gnt1 = 1'b1;
    end else begin
      gnt0 = cand0;
      gnt1 = cand1;
    end
  end

  // Readies are held low while reset is asserted.
  assign req0_ready = gnt0 && rst;
  assign req1_ready = gnt1 && rst;

  always_comb begin
    nxt_a   = '0;
    nxt_b   = '0;
    nxt_op  = ALU_NOP;
    nxt_tag = TAG_NONE;
    unique case (1'b1)
      gnt0: begin
        nxt_a   = req0_a;
        nxt_b   = req0_b;
        nxt_op  = req0_op;
        nxt_tag = TAG_R0;
      end
      gnt1: begin
        nxt_a   = req1_a;
        nxt_b   = req1_b;
        nxt_op  = req1_op;
        nxt_tag = TAG_R1;
      end
      default: ;
    endcase
  end

  assign wr0 = (tag2 == TAG_R0);
  assign wr1 = (tag2 == TAG_R1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= ALU_NOP;
      tag1   <= TAG_NONE;
      tag2   <= TAG_NONE;
      last1  <= 1'b1;
    end else begin
      alu_a  <= nxt_a;
      alu_b  <= nxt_b;
      alu_op <= nxt_op;
      tag1   <= nxt_tag;
      tag2   <= tag1;
      if (gnt0 || gnt1) last1 <= gnt1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight0   <= 1'b0;
      rsp0_valid  <= 1'b0;
      rsp0_result <= '0;
      rsp0_z      <= 1'b0;
      rsp0_v      <= 1'b0;
    end else begin
      if (gnt0) inflight0 <= 1'b1;
      else if (wr0) inflight0 <= 1'b0;
      if (wr0) begin
        rsp0_valid  <= 1'b1;
        rsp0_result <= alu_result;
        rsp0_z      <= alu_z;
        rsp0_v      <= alu_v;
      end else if (rsp0_ready) begin
        rsp0_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight1   <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp1_result <= '0;
      rsp1_z      <= 1'b0;
      rsp1_v      <= 1'b0;
    end else begin
      if (gnt1) inflight1 <= 1'b1;
      else if (wr1) inflight1 <= 1'b0;
      if (wr1) begin
        rsp1_valid  <= 1'b1;
        rsp1_result <= alu_result;
        rsp1_z      <= alu_z;
        rsp1_v      <= alu_v;
      end else if (rsp1_ready) begin
        rsp1_valid <= 1'b0;
      end
    end
  end

endmodule
